// File: rtl/regfile_multiport_if.sv
// Bundle between the pipeline and the register file: read ports,
// write ports A/B, issue and scoreboard. master = pipeline, slave = regfile.
interface regfile_multiport_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_READ   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_READ*AW-1:0]         rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
  logic [NUM_READ-1:0]            rd_busy;
  logic                           wa_en;
  logic [AW-1:0]                  wa_addr;
  logic [DATA_WIDTH-1:0]          wa_data;
  logic                           wb_en;
  logic [AW-1:0]                  wb_addr;
  logic [DATA_WIDTH-1:0]          wb_data;
  logic                           iss_en;
  logic [AW-1:0]                  iss_addr;
  logic [NUM_REGS-1:0]            busy_vec;

  modport master (
    output rd_addr,
    input  rd_data, rd_busy,
    output wa_en, wa_addr, wa_data,
    output wb_en, wb_addr, wb_data,
    output iss_en, iss_addr,
    input  busy_vec
  );

  modport slave (
    input  rd_addr,
    output rd_data, rd_busy,
    input  wa_en, wa_addr, wa_data,
    input  wb_en, wb_addr, wb_data,
    input  iss_en, iss_addr,
    output busy_vec
  );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-read, dual-write register file with pending-write scoreboard.
// Ports: clk, rst (async high), bus (regfile_multiport_if.slave):
//   rd_addr/rd_data/rd_busy  NUM_READ combinational read ports
//   wa_* ALU writeback, wb_* load writeback (B wins on collision)
//   iss_en/iss_addr mark a destination pending; busy_vec = scoreboard.
// Option: REGFILE_BYPASS_EN forwards same-cycle writes to reads.
module regfile_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_READ   = 2
) (
  input logic                clk,
  input logic                rst,
  regfile_multiport_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic [AW-1:0]         ra;

  logic wa_ok;
  logic wb_ok;

  assign wa_ok = bus.wa_en && (bus.wa_addr != '0);
  assign wb_ok = bus.wb_en && (bus.wb_addr != '0);

  // Port B is applied last so it overrides A on a collision.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    if (wa_ok) regs_d[bus.wa_addr] = bus.wa_data;
    if (wb_ok) regs_d[bus.wb_addr] = bus.wb_data;
    regs_d[0] = '0;
  end

  // A new producer issued on the completing edge keeps the reg busy.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (bus.iss_en && (bus.iss_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if ((wa_ok && (bus.wa_addr == AW'(r))) ||
                   (wb_ok && (bus.wb_addr == AW'(r)))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

  assign bus.busy_vec = busy_q;

`ifdef REGFILE_BYPASS_EN
  logic iss_hit;
`endif

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    ra = '0;
`ifdef REGFILE_BYPASS_EN
    iss_hit = 1'b0;
`endif
    for (int i = 0; i < NUM_READ; i++) begin
      ra = bus.rd_addr[i*AW +: AW];
      bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra];
      bus.rd_busy[i] = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      // A same-cycle re-issue keeps the stored busy bit visible.
      iss_hit = bus.iss_en && (bus.iss_addr == ra);
      if (wb_ok && (bus.wb_addr == ra)) begin
        bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.wb_data;
        if (!iss_hit) bus.rd_busy[i] = 1'b0;
      end else if (wa_ok && (bus.wa_addr == ra)) begin
        bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = bus.wa_data;
        if (!iss_hit) bus.rd_busy[i] = 1'b0;
      end
`endif
    end
  end
endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single-write RV32 register file.
- Configurable data width, register count and number of read ports.
- Two write ports (ALU writeback and load writeback), with fixed priority between them.
- Integrated per-register pending-write scoreboard, used by the pipeline hazard unit to stall on RAW dependencies.
- Sits between decode (read/issue) and writeback stages.

Parameters:
- DATA_WIDTH, 32, bits per register
- NUM_REGS, 32, number of architectural registers (power of 2, >=2)
- NUM_READ, 2, number of combinational read ports (1..4)
- AW, $clog2(NUM_REGS), address width (derived, localparam)

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- rd_addr  input  NUM_READ*AW  packed read addresses; port i at [i*AW +: AW]
- rd_data  output  NUM_READ*DATA_WIDTH  packed read data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
- rd_busy  output  NUM_READ  1 = register addressed by read port i has a pending write
- wa_en  input  1  write port A enable (ALU writeback)
- wa_addr  input  AW  write port A address
- wa_data  input  DATA_WIDTH  write port A data
- wb_en  input  1  write port B enable (load writeback)
- wb_addr  input  AW  write port B address
- wb_data  input  DATA_WIDTH  write port B data
- iss_en  input  1  issue: mark iss_addr pending
- iss_addr  input  AW  destination register of the issuing instruction
- busy_vec  output  NUM_REGS  scoreboard state, bit r = register r pending

Behaviour:
- Reset (async, rst=1):
  - All registers clear to 0; busy_vec = 0 immediately.
  - rd_data reads 0 for every port; rd_busy = 0.
  - Writes and issues are ignored while rst=1.
- Register 0:
  - Always reads 0.
  - Writes to it are discarded.
  - Never marked busy; busy_vec[0] is constant 0.
- Reads:
  - Combinational, zero latency: rd_data[i] = reg[rd_addr[i]].
  - rd_busy[i] = busy_vec[rd_addr[i]].
- Writes:
  - Committed on posedge clk when the enable is set and addr != 0.
  - New value is visible on reads the cycle after the edge.
- Write collision (wa_en & wb_en & wa_addr == wb_addr): port B wins; port A data is dropped.
- Scoreboard (per register r != 0), evaluated on posedge:
  - set = iss_en & iss_addr == r
  - clr = (wa_en & wa_addr == r) | (wb_en & wb_addr == r)
  - set & clr same edge: busy ends 1 (new producer supersedes the completing one).
  - clr only: busy -> 0. set only: busy -> 1. Neither: hold.
  - Write to a non-busy register is legal: it writes and busy stays 0.
  - Re-issue to an already-busy register keeps busy = 1; there is no counting.
- Reset mid-operation: all pending state is lost; busy_vec = 0 and contents = 0 regardless of in-flight issue/write.
- No X propagation: out-of-range addresses are impossible (NUM_REGS = 2^AW).

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined (write-to-read forwarding):
  - If a read address matches an enabled, non-zero write address in the same cycle, rd_data returns that write's data combinationally; port B has priority over port A.
  - rd_busy[i] is forced 0 on a match, unless iss_en & iss_addr == rd_addr[i] in the same cycle, in which case it stays at the stored busy value.
- Undefined:
  - Reads return the stored (pre-edge) value.
  - rd_busy reflects the stored busy_vec only.

Test Plan:
1. Assert rst mid-cycle after writing x5=0xDEADBEEF and issuing x7 -> rd_data reads 0 for x5 immediately, busy_vec=0 without waiting for clk.
2. wa_en=1 wa_addr=0 wa_data=0x12345678, then read x0 -> 0; busy_vec[0]=0 after iss_en with iss_addr=0.
3. Same edge: wa_addr=wb_addr=3, wa_data=0x11, wb_data=0x22 -> x3 reads 0x22 next cycle.
4. iss x9 cycle 1 -> busy_vec[9]=1 cycle 2; wa x9=0xAA plus iss x9 same edge -> busy stays 1, x9=0xAA; later wb x9=0xBB alone -> busy 0.
5. REGFILE_BYPASS_EN: x4=0x1 stored, wb x4=0x55 while rd_addr[0]=4 -> rd_data[0]=0x55 same cycle, rd_busy[0]=0. Without the macro -> 0x1 that cycle, 0x55 next.
6. NUM_REGS=16, NUM_READ=3, DATA_WIDTH=64: write 0xFFFF_0000_FFFF_0001 to x15, read on all 3 ports -> identical values; rd_busy correct per port.
